// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
//   Bundle of every non-clock/non-reset signal of the IF stage.
//   Control in : en, branchTaken, branchTarget
//   Memory     : imem_addr (to memory), imem_rdata (from memory, 1-cycle latency)
//   IF/ID out  : inst_out, pc_out, valid_out
//   Status     : halted, fetch_count
//   Modports   : slave  - the fetch stage itself
//                master - the environment (pipeline control + instruction memory)
// ---------------------------------------------------------------------------
interface instruction_fetch_if #(
  parameter int PC_WIDTH   = 24,
  parameter int INST_WIDTH = 32
) ();

  logic                  en;
  logic                  branchTaken;
  logic [PC_WIDTH-1:0]   branchTarget;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic [INST_WIDTH-1:0] imem_rdata;
  logic [INST_WIDTH-1:0] inst_out;
  logic [PC_WIDTH-1:0]   pc_out;
  logic                  valid_out;
  logic                  halted;
  logic [31:0]           fetch_count;

  modport slave (
    input  en,
    input  branchTaken,
    input  branchTarget,
    input  imem_rdata,
    output imem_addr,
    output inst_out,
    output pc_out,
    output valid_out,
    output halted,
    output fetch_count
  );

  modport master (
    output en,
    output branchTaken,
    output branchTarget,
    output imem_rdata,
    input  imem_addr,
    input  inst_out,
    input  pc_out,
    input  valid_out,
    input  halted,
    input  fetch_count
  );

endinterface

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   IF stage: owns the fetch PC, drives a synchronous-read instruction memory
//   and registers {valid, pc, inst} into the IF/ID boundary.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-low reset
//     bus  - instruction_fetch_if.slave (stall, redirect, memory, IF/ID, status)
//   Handles stall (en=0), taken-branch redirect, HALT instruction and the
//   post-reset bubble, and counts delivered instructions.
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                      PC_WIDTH   = 24,
  parameter int                      INST_WIDTH = 32,
  parameter int unsigned             PC_STEP    = 1,
  parameter logic [PC_WIDTH-1:0]     RESET_PC   = 24'h000000,
  parameter logic [INST_WIDTH-1:0]   NOP_INST   = 32'h00000000,
  parameter logic [INST_WIDTH-1:0]   HALT_INST  = 32'hFFFFFFFF
) (
  input  logic               clk,
  input  logic               rst,
  instruction_fetch_if.slave bus
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  logic [1:0]            state_q,       state_d;
  logic [PC_WIDTH-1:0]   pc_f_q,        pc_f_d;
  logic [PC_WIDTH-1:0]   req_pc_q,      req_pc_d;
  logic                  req_valid_q,   req_valid_d;
  logic [INST_WIDTH-1:0] inst_q,        inst_d;
  logic [PC_WIDTH-1:0]   pc_q,          pc_d;
  logic                  valid_q,       valid_d;
  logic [31:0]           count_q,       count_d;

  logic                  fetching;
  logic                  halt_seen;

  // BOOT and RUN both advance the PC when the pipeline moves.
  assign fetching  = bus.en && ((state_q == ST_RUN) || (state_q == ST_BOOT));
  assign halt_seen = req_valid_q && (bus.imem_rdata == HALT_INST);

  // While stalled or halted the held request is re-presented so that
  // imem_rdata keeps returning the word belonging to req_pc_q.
  always_comb begin
    if (bus.branchTaken) begin
      bus.imem_addr = bus.branchTarget;
    end else if (fetching) begin
      bus.imem_addr = pc_f_q;
    end else begin
      bus.imem_addr = req_pc_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    count_d     = count_q;

    if (bus.branchTaken) begin
      // Redirect beats stall and HALT; the wrong-path word in flight
      // (possibly a HALT) is dropped by latching a bubble.
      valid_d     = 1'b0;
      inst_d      = NOP_INST;
      req_pc_d    = bus.branchTarget;
      req_valid_d = 1'b1;
      pc_f_d      = bus.branchTarget + STEP;
      state_d     = ST_RUN;
    end else if (bus.en) begin
      case (state_q)
        ST_BOOT: begin
          valid_d     = 1'b0;
          inst_d      = NOP_INST;
          req_pc_d    = pc_f_q;
          req_valid_d = 1'b1;
          pc_f_d      = pc_f_q + STEP;
          state_d     = ST_RUN;
        end
        ST_RUN: begin
          valid_d     = req_valid_q;
          pc_d        = req_pc_q;
          inst_d      = req_valid_q ? bus.imem_rdata : NOP_INST;
          req_pc_d    = pc_f_q;
          req_valid_d = 1'b1;
          pc_f_d      = pc_f_q + STEP;
          if (req_valid_q) begin
            count_d = count_q + 32'd1;
          end
          if (halt_seen) begin
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
        end
        default: begin
          // Unreachable encoding: fall back to a clean restart of fetch.
          valid_d     = 1'b0;
          inst_d      = NOP_INST;
          req_valid_d = 1'b0;
          state_d     = ST_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_BOOT;
      pc_f_q      <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
      inst_q      <= NOP_INST;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
    end
  end

  assign bus.inst_out    = inst_q;
  assign bus.pc_out      = pc_q;
  assign bus.valid_out   = valid_q;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  localparam logic [31:0] NOP  = 32'h00000000;

  logic clk;
  logic rst;
  instruction_fetch_if bus ();

  instruction_fetch dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory (256 words, aliased on low address bits).
  logic [31:0] mem [0:255];
  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr[7:0]];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: what the decode stage should see, expressed as
  // "next PC to deliver" plus a count of warm-up bubbles still owed.
  logic [23:0] m_next;
  int          m_warm;
  logic        m_halted;
  logic        m_valid;
  logic [23:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_count;

  task automatic model_reset();
    m_next = 24'h0; m_warm = 1; m_halted = 1'b0;
    m_valid = 1'b0; m_pc = 24'h0; m_inst = NOP; m_count = 32'h0;
  endtask

  task automatic model_step(input logic e, input logic b, input logic [23:0] t);
    if (b) begin
      m_valid = 1'b0; m_inst = NOP; m_next = t; m_warm = 0; m_halted = 1'b0;
    end else if (e) begin
      if (m_halted || m_warm > 0) begin
        m_valid = 1'b0; m_inst = NOP;
        if (m_warm > 0) m_warm = m_warm - 1;
      end else begin
        m_valid = 1'b1; m_pc = m_next; m_inst = mem[m_next[7:0]];
        m_count = m_count + 1;
        if (m_inst == HALT) m_halted = 1'b1;
        m_next = m_next + 24'd1;
      end
    end
  endtask

  function automatic logic [89:0] obs_vec();
    return {bus.valid_out, (bus.valid_out ? bus.pc_out : 24'h0), bus.inst_out,
            bus.halted, bus.fetch_count};
  endfunction

  function automatic logic [89:0] exp_vec();
    return {m_valid, (m_valid ? m_pc : 24'h0), (m_valid ? m_inst : NOP),
            m_halted, m_count};
  endfunction

  task automatic step(input logic e, input logic b, input logic [23:0] t);
    bus.en = e; bus.branchTaken = b; bus.branchTarget = t;
    @(posedge clk);
    model_step(e, b, t);
    #1;
    bus.branchTaken = 1'b0;
    cyc++;
    $display("txn %0d en=%0d br=%0d tgt=%h -> v=%0d pc=%h inst=%h halted=%0d cnt=%0d",
             cyc, e, b, t, bus.valid_out, bus.pc_out, bus.inst_out, bus.halted, bus.fetch_count);
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;
  endtask

  task automatic apply_reset();
    bus.en = 1'b0; bus.branchTaken = 1'b0; bus.branchTarget = 24'h0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [89:0] obs;
    fill_linear();
    bus.en = 1'b1; bus.branchTaken = 1'b0; bus.branchTarget = 24'h0;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    obs = obs_vec();
    total++;
    if (obs !== 90'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", obs, 90'h0);
    end
    bus.en = 1'b0;
    #1;
    total++;
    if (bus.imem_addr !== 24'h0) begin
      bad++; $display("FAIL reset_imem_addr got=%h want=%h", bus.imem_addr, 24'h0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_sequential();
    logic [89:0] obs, expv;
    fill_linear();
    apply_reset();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 24'h0);
      obs = obs_vec(); expv = exp_vec(); total++;
      if (obs !== expv) begin
        bad++; $display("FAIL seq_cycle%0d got=%h want=%h", i, obs, expv);
      end
      if (i == 2) begin
        total++;
        if ({bus.valid_out, bus.pc_out, bus.inst_out} !== {1'b1, 24'h0, 32'h100}) begin
          bad++; $display("FAIL seq_first_valid got=%0d/%h/%h want=1/000000/00000100",
                          bus.valid_out, bus.pc_out, bus.inst_out);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [89:0] obs, expv;
    int guard;
    fill_linear();
    apply_reset();
    guard = 0;
    while (!(m_valid && m_pc == 24'd5) && guard < 30) begin
      step(1'b1, 1'b0, 24'h0); guard++;
    end
    total++;
    if (guard >= 30) begin
      bad++; $display("FAIL stall_reach_pc5 got=timeout want=pc5");
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 24'h0);
      obs = obs_vec(); expv = exp_vec(); total++;
      if (obs !== expv || bus.pc_out !== 24'd5 || bus.inst_out !== 32'h105) begin
        bad++; $display("FAIL stall_hold%0d got=%h want=%h", i, obs, expv);
      end
    end
    step(1'b1, 1'b0, 24'h0);
    obs = obs_vec(); expv = exp_vec(); total++;
    if (obs !== expv || bus.pc_out !== 24'd6 || bus.inst_out !== 32'h106) begin
      bad++; $display("FAIL stall_resume got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_branch();
    logic [89:0] obs, expv;
    logic [31:0] cnt_before;
    int guard;
    fill_linear();
    apply_reset();
    guard = 0;
    while (!(m_valid && m_pc == 24'd8) && guard < 30) begin
      step(1'b1, 1'b0, 24'h0); guard++;
    end
    cnt_before = bus.fetch_count;
    step(1'b1, 1'b1, 24'h40);
    obs = obs_vec(); expv = exp_vec(); total++;
    if (obs !== expv || bus.valid_out !== 1'b0 || bus.fetch_count !== cnt_before) begin
      bad++; $display("FAIL branch_bubble got=%h want=%h", obs, expv);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 24'h0);
      obs = obs_vec(); expv = exp_vec(); total++;
      if (obs !== expv || bus.pc_out !== 24'h40 + i || bus.inst_out !== 32'h140 + i) begin
        bad++; $display("FAIL branch_target%0d got=%h want=%h", i, obs, expv);
      end
    end
  endtask

  task automatic test_halt();
    logic [89:0] obs, expv;
    fill_linear();
    mem[3] = HALT;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 24'h0);
      obs = obs_vec(); expv = exp_vec(); total++;
      if (obs !== expv) begin
        bad++; $display("FAIL halt_cycle%0d got=%h want=%h", i, obs, expv);
      end
    end
    total++;
    if (bus.halted !== 1'b1 || bus.fetch_count !== 32'd4) begin
      bad++; $display("FAIL halt_frozen got=h%0d/c%0d want=h1/c4", bus.halted, bus.fetch_count);
    end
    step(1'b1, 1'b1, 24'h0);
    step(1'b1, 1'b0, 24'h0);
    obs = obs_vec(); expv = exp_vec(); total++;
    if (obs !== expv || bus.pc_out !== 24'h0 || bus.valid_out !== 1'b1 || bus.halted !== 1'b0) begin
      bad++; $display("FAIL halt_resume got=%h want=%h", obs, expv);
    end
    mem[3] = 32'h103;
  endtask

  task automatic test_branch_in_stall();
    logic [89:0] obs, expv;
    fill_linear();
    apply_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 24'h0);
    step(1'b0, 1'b1, 24'h20);
    step(1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b0, 24'h0);
    obs = obs_vec(); expv = exp_vec(); total++;
    if (obs !== expv) begin
      bad++; $display("FAIL stallbr_hold got=%h want=%h", obs, expv);
    end
    step(1'b1, 1'b0, 24'h0);
    obs = obs_vec(); expv = exp_vec(); total++;
    if (obs !== expv || bus.pc_out !== 24'h20 || bus.inst_out !== 32'h120) begin
      bad++; $display("FAIL stallbr_target got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_halt_branch_collision();
    logic [89:0] obs, expv;
    int guard;
    fill_linear();
    mem[6] = HALT;
    apply_reset();
    guard = 0;
    while (!(m_next == 24'd6 && m_warm == 0) && guard < 30) begin
      step(1'b1, 1'b0, 24'h0); guard++;
    end
    step(1'b1, 1'b1, 24'h10);
    obs = obs_vec(); expv = exp_vec(); total++;
    if (obs !== expv || bus.halted !== 1'b0 || bus.valid_out !== 1'b0) begin
      bad++; $display("FAIL collide_flush got=%h want=%h", obs, expv);
    end
    step(1'b1, 1'b0, 24'h0);
    obs = obs_vec(); expv = exp_vec(); total++;
    if (obs !== expv || bus.pc_out !== 24'h10) begin
      bad++; $display("FAIL collide_target got=%h want=%h", obs, expv);
    end
    mem[6] = 32'h106;
  endtask

  task automatic test_async_reset();
    logic [89:0] obs, expv;
    fill_linear();
    apply_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 24'h0);
    rst = 1'b0;
    model_reset();
    #2;
    obs = obs_vec(); total++;
    if (obs !== 90'h0) begin
      bad++; $display("FAIL async_reset got=%h want=%h", obs, 90'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 24'h0);
      obs = obs_vec(); expv = exp_vec(); total++;
      if (obs !== expv) begin
        bad++; $display("FAIL async_restart%0d got=%h want=%h", i, obs, expv);
      end
    end
  endtask

  task automatic test_random();
    logic [89:0] obs, expv;
    logic e, b;
    logic [23:0] t;
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 11) == 0);
      t = 24'($urandom_range(0, 255));
      step(e, b, t);
      obs = obs_vec(); expv = exp_vec(); total++;
      if (obs !== expv) begin
        bad++; $display("FAIL random%0d got=%h want=%h", i, obs, expv);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.en = 1'b0; bus.branchTaken = 1'b0; bus.branchTarget = 24'h0;
    bus.imem_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_halt();
    test_branch_in_stall();
    test_halt_branch_collision();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
